// File: rtl/simple_cpu_v2_pkg.sv
// Shared opcodes, FSM state and ALU op encodings for the parametrised accumulator CPU.
package simple_cpu_v2_pkg;

  localparam logic [7:0] OpNop  = 8'h00;
  localparam logic [7:0] OpLdi  = 8'h01;
  localparam logic [7:0] OpLd   = 8'h02;
  localparam logic [7:0] OpSt   = 8'h03;
  localparam logic [7:0] OpAdd  = 8'h04;
  localparam logic [7:0] OpSub  = 8'h05;
  localparam logic [7:0] OpAnd  = 8'h06;
  localparam logic [7:0] OpOr   = 8'h07;
  localparam logic [7:0] OpXor  = 8'h08;
  localparam logic [7:0] OpAddi = 8'h09;
  localparam logic [7:0] OpJmp  = 8'h0A;
  localparam logic [7:0] OpJz   = 8'h0B;
  localparam logic [7:0] OpJc   = 8'h0C;
  localparam logic [7:0] OpCall = 8'h0D;
  localparam logic [7:0] OpRet  = 8'h0E;
  localparam logic [7:0] OpHalt = 8'h0F;

  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagC = 1;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  typedef enum logic [2:0] {AluPass, AluAdd, AluSub, AluAnd, AluOr, AluXor} alu_op_e;

endpackage

// File: rtl/simple_cpu_v2_alu.sv
// Combinational ALU; res[DATA_W] is carry for add, borrow for sub, zero otherwise.
module simple_cpu_v2_alu
  import simple_cpu_v2_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W:0]   res
);

  always_comb begin
    res = {1'b0, b};
    case (op)
      AluPass: res = {1'b0, b};
      AluAdd:  res = {1'b0, a} + {1'b0, b};
      AluSub:  res = {1'b0, a} - {1'b0, b};
      AluAnd:  res = {1'b0, a & b};
      AluOr:   res = {1'b0, a | b};
      AluXor:  res = {1'b0, a ^ b};
      default: res = {1'b0, b};
    endcase
  end

endmodule

// File: rtl/simple_cpu_v2.sv
// Accumulator CPU with ready/valid instruction and data buses, Z/C flags,
// conditional jumps, a CALL/RET return stack and halt/fault reporting.
module simple_cpu_v2
  import simple_cpu_v2_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IM_AW       = 8,
  parameter int unsigned DM_AW       = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              im_valid,
  output logic [IM_AW-1:0]  im_addr,
  input  logic              im_ready,
  input  logic [DATA_W+7:0] im_instr,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [DM_AW-1:0]  dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);
  localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

  state_e              state_q;
  logic [IM_AW-1:0]    pc_q;
  logic [DATA_W-1:0]   acc_q;
  logic [1:0]          flags_q;
  logic [7:0]          op_q;
  logic [DATA_W-1:0]   operand_q;
  logic [IM_AW-1:0]    stack_q [STACK_DEPTH];
  logic [SpW-1:0]      sp_q;
  logic                im_valid_q, dm_rd_q, dm_wr_q, halted_q, fault_q;

  logic [IM_AW-1:0]    pc_inc, jmp_tgt, stack_top;
  logic [DATA_W-1:0]   alu_b;
  logic [2:0]          alu_op;
  logic [DATA_W:0]     alu_res;
  logic [1:0]          flags_new;
  logic                stop;

  assign pc_inc  = pc_q + 1'b1;
  assign jmp_tgt = operand_q[IM_AW-1:0];

  // Any of these ends execution; only a plain HALT leaves fault clear.
  assign stop = (op_q > OpHalt) || (op_q == OpHalt) ||
                (op_q == OpCall && sp_q == SpFull) ||
                (op_q == OpRet && sp_q == '0);

  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SpW'(i + 1)) stack_top = stack_q[i];
    end
  end

  always_comb begin
    alu_b  = dm_rdata;
    alu_op = AluPass;
    case (op_q)
      OpLdi:   alu_b = operand_q;
      OpAddi:  begin alu_b = operand_q; alu_op = AluAdd; end
      OpAdd:   alu_op = AluAdd;
      OpSub:   alu_op = AluSub;
      OpAnd:   alu_op = AluAnd;
      OpOr:    alu_op = AluOr;
      OpXor:   alu_op = AluXor;
      default: ;
    endcase
  end

  simple_cpu_v2_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a  (acc_q),
    .b  (alu_b),
    .op (alu_op),
    .res(alu_res)
  );

  always_comb begin
    flags_new        = '0;
    flags_new[FlagZ] = (alu_res[DATA_W-1:0] == '0);
    flags_new[FlagC] = alu_res[DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      acc_q      <= '0;
      flags_q    <= '0;
      op_q       <= '0;
      operand_q  <= '0;
      sp_q       <= '0;
      im_valid_q <= 1'b0;
      dm_rd_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (im_valid_q && im_ready) begin
            op_q       <= im_instr[DATA_W+7:DATA_W];
            operand_q  <= im_instr[DATA_W-1:0];
            im_valid_q <= 1'b0;
            state_q    <= StExec;
          end else begin
            im_valid_q <= 1'b1;
          end
        end
        StExec: begin
          if (stop) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            fault_q  <= (op_q != OpHalt);
          end else begin
            state_q    <= StFetch;
            im_valid_q <= 1'b1;
            pc_q       <= pc_inc;
            case (op_q)
              OpLdi, OpAddi: begin
                acc_q   <= alu_res[DATA_W-1:0];
                flags_q <= flags_new;
              end
              OpLd, OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
                state_q    <= StMem;
                im_valid_q <= 1'b0;
                pc_q       <= pc_q;
                dm_rd_q    <= 1'b1;
              end
              OpSt: begin
                state_q    <= StMem;
                im_valid_q <= 1'b0;
                pc_q       <= pc_q;
                dm_wr_q    <= 1'b1;
              end
              OpJmp: pc_q <= jmp_tgt;
              OpJz:  if (flags_q[FlagZ]) pc_q <= jmp_tgt;
              OpJc:  if (flags_q[FlagC]) pc_q <= jmp_tgt;
              OpCall: begin
                for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                  if (sp_q == SpW'(i)) stack_q[i] <= pc_inc;
                end
                sp_q <= sp_q + 1'b1;
                pc_q <= jmp_tgt;
              end
              OpRet: begin
                sp_q <= sp_q - 1'b1;
                pc_q <= stack_top;
              end
              default: ;
            endcase
          end
        end
        StMem: begin
          if (dm_ready) begin
            dm_rd_q    <= 1'b0;
            dm_wr_q    <= 1'b0;
            pc_q       <= pc_inc;
            im_valid_q <= 1'b1;
            state_q    <= StFetch;
            if (dm_rd_q) begin
              acc_q   <= alu_res[DATA_W-1:0];
              flags_q <= flags_new;
            end
          end
        end
        StHalt: ;
      endcase
    end
  end

  assign im_valid = im_valid_q;
  assign im_addr  = pc_q;
  assign dm_rd    = dm_rd_q;
  assign dm_wr    = dm_wr_q;
  assign dm_addr  = operand_q[DM_AW-1:0];
  assign dm_wdata = acc_q;
  assign acc_out  = acc_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_simple_cpu_v2.sv
// Directed bench: an 8-bit core with a 2-deep stack and wait-state RAM, plus a 16-bit core.
module tb_simple_cpu_v2;

  localparam logic [7:0] OpNop = 8'h00, OpLdi = 8'h01, OpLd = 8'h02, OpSt = 8'h03;
  localparam logic [7:0] OpAdd = 8'h04, OpSub = 8'h05, OpAnd = 8'h06, OpOr = 8'h07;
  localparam logic [7:0] OpXor = 8'h08, OpAddi = 8'h09, OpJmp = 8'h0A, OpJz = 8'h0B;
  localparam logic [7:0] OpJc = 8'h0C, OpCall = 8'h0D, OpRet = 8'h0E, OpHalt = 8'h0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core A: 8-bit data, 2-entry stack, RAM with programmable wait states
  logic        rst_a, im_valid_a, im_ready_a, dm_rd_a, dm_wr_a, dm_ready_a, halted_a, fault_a;
  logic [7:0]  im_addr_a, dm_addr_a, dm_wdata_a, dm_rdata_a, acc_a;
  logic [15:0] im_instr_a;
  logic [15:0] rom_a [256];
  logic [7:0]  ram_a [256];
  int          wait_a = 0;
  int          wcnt_a = 0;
  logic [7:0]  log_a [$];
  logic [7:0]  lacc_a [$];
  int          lt_a [$];

  assign im_instr_a = rom_a[im_addr_a];
  assign dm_rdata_a = ram_a[dm_addr_a];
  assign dm_ready_a = (dm_rd_a || dm_wr_a) && (wcnt_a >= wait_a);

  always @(posedge clk) begin
    if (dm_wr_a && dm_ready_a) ram_a[dm_addr_a] <= dm_wdata_a;
    if ((dm_rd_a || dm_wr_a) && !dm_ready_a) wcnt_a <= wcnt_a + 1;
    else wcnt_a <= 0;
    if (rst_a && im_valid_a && im_ready_a) begin
      log_a.push_back(im_addr_a);
      lacc_a.push_back(acc_a);
      lt_a.push_back(cyc);
    end
  end

  simple_cpu_v2 #(
    .DATA_W(8), .IM_AW(8), .DM_AW(8), .STACK_DEPTH(2)
  ) dut_a (
    .clk(clk), .reset(rst_a), .im_valid(im_valid_a), .im_addr(im_addr_a),
    .im_ready(im_ready_a), .im_instr(im_instr_a), .dm_rd(dm_rd_a), .dm_wr(dm_wr_a),
    .dm_addr(dm_addr_a), .dm_wdata(dm_wdata_a), .dm_rdata(dm_rdata_a), .dm_ready(dm_ready_a),
    .acc_out(acc_a), .halted(halted_a), .fault(fault_a)
  );

  // Core B: 16-bit data, 6-bit instruction address, zero-wait RAM
  logic        rst_b, im_valid_b, im_ready_b, dm_rd_b, dm_wr_b, dm_ready_b, halted_b, fault_b;
  logic [5:0]  im_addr_b;
  logic [7:0]  dm_addr_b;
  logic [15:0] dm_wdata_b, dm_rdata_b, acc_b;
  logic [23:0] im_instr_b;
  logic [23:0] rom_b [64];
  logic [15:0] ram_b [256];
  logic [5:0]  log_b [$];
  logic [15:0] lacc_b [$];

  assign im_instr_b = rom_b[im_addr_b];
  assign dm_rdata_b = ram_b[dm_addr_b];
  assign dm_ready_b = 1'b1;

  always @(posedge clk) begin
    if (dm_wr_b) ram_b[dm_addr_b] <= dm_wdata_b;
    if (rst_b && im_valid_b && im_ready_b) begin
      log_b.push_back(im_addr_b);
      lacc_b.push_back(acc_b);
    end
  end

  simple_cpu_v2 #(
    .DATA_W(16), .IM_AW(6), .DM_AW(8), .STACK_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(rst_b), .im_valid(im_valid_b), .im_addr(im_addr_b),
    .im_ready(im_ready_b), .im_instr(im_instr_b), .dm_rd(dm_rd_b), .dm_wr(dm_wr_b),
    .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b), .dm_rdata(dm_rdata_b), .dm_ready(dm_ready_b),
    .acc_out(acc_b), .halted(halted_b), .fault(fault_b)
  );

  task automatic clear_rom_a();
    for (int i = 0; i < 256; i++) rom_a[i] = {OpHalt, 8'h00};
  endtask

  task automatic start_a();
    @(negedge clk);
    rst_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic run_a(input int budget);
    for (int c = 0; c < budget && halted_a !== 1'b1; c++) @(negedge clk);
    nvec++;
    if (halted_a !== 1'b1) begin
      nerr++;
      $display("FAIL halt_timeout_a: halted=%b, expected 1", halted_a);
    end
  endtask

  task automatic test_reset();
    clear_rom_a();
    rom_a[0] = {OpLdi, 8'h33};
    @(negedge clk);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({im_valid_a, dm_rd_a, dm_wr_a, halted_a, fault_a} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {im_valid_a, dm_rd_a, dm_wr_a, halted_a, fault_a});
    end
    nvec++;
    if ({im_addr_a, dm_addr_a, dm_wdata_a, acc_a} !== 32'h0) begin
      nerr++;
      $display("FAIL reset_data: got %h expected 00000000",
               {im_addr_a, dm_addr_a, dm_wdata_a, acc_a});
    end
    rst_a = 1'b1;
    @(negedge clk);
    nvec++;
    if (im_valid_a !== 1'b1 || im_addr_a !== 8'h00) begin
      nerr++;
      $display("FAIL reset_first_fetch: valid=%b addr=%h expected 1/00", im_valid_a, im_addr_a);
    end
    run_a(50);
    nvec++;
    if (acc_a !== 8'h33 || fault_a !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ldi: acc=%h fault=%b expected 33/0", acc_a, fault_a);
    end
  endtask

  task automatic test_arith();
    logic [7:0] exp [7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd9};
    int base;
    clear_rom_a();
    rom_a[0] = {OpLdi, 8'd5};
    rom_a[1] = {OpAddi, 8'd250};
    rom_a[2] = {OpJc, 8'd6};
    rom_a[3] = {OpAddi, 8'd1};
    rom_a[4] = {OpJz, 8'd7};
    rom_a[7] = {OpJc, 8'd9};
    base = log_a.size();
    start_a();
    run_a(100);
    nvec++;
    if (log_a.size() - base != 7) begin
      nerr++;
      $display("FAIL arith_nfetch: got %0d expected 7", log_a.size() - base);
    end
    for (int i = 0; i < 7; i++) begin
      nvec++;
      if (base + i >= log_a.size() || log_a[base + i] !== exp[i]) begin
        nerr++;
        $display("FAIL arith_pc[%0d]: got %h expected %h", i,
                 (base + i < log_a.size()) ? log_a[base + i] : 8'hxx, exp[i]);
      end
    end
    nvec++;
    if (lacc_a.size() < base + 5 || lacc_a[base + 3] !== 8'hFF || lacc_a[base + 4] !== 8'h00)
    begin
      nerr++;
      $display("FAIL arith_acc: acc at pc3/pc4 not FF/00");
    end
    nvec++;
    if (lt_a.size() < base + 7 || lt_a[base + 6] - lt_a[base] != 12) begin
      nerr++;
      $display("FAIL arith_latency: six register ops did not take 12 cycles");
    end
    nvec++;
    if (acc_a !== 8'h00 || fault_a !== 1'b0) begin
      nerr++;
      $display("FAIL arith_final: acc=%h fault=%b expected 00/0", acc_a, fault_a);
    end
  endtask

  task automatic test_mem();
    int base, wr_cyc, rd_cyc, bad, both, lost;
    logic prev_rdy;
    clear_rom_a();
    rom_a[0] = {OpLdi, 8'hA5};
    rom_a[1] = {OpSt, 8'h10};
    rom_a[2] = {OpLdi, 8'h00};
    rom_a[3] = {OpLd, 8'h10};
    wait_a = 2;
    wr_cyc = 0; rd_cyc = 0; bad = 0; both = 0; lost = 0; prev_rdy = 1'b0;
    base = log_a.size();
    start_a();
    for (int c = 0; c < 100 && halted_a !== 1'b1; c++) begin
      if (dm_wr_a) begin
        wr_cyc++;
        if (dm_addr_a !== 8'h10 || dm_wdata_a !== 8'hA5) bad++;
      end
      if (dm_rd_a) begin
        rd_cyc++;
        if (dm_addr_a !== 8'h10) bad++;
      end
      if (dm_rd_a && dm_wr_a) both++;
      if (prev_rdy && im_valid_a !== 1'b1) lost++;
      prev_rdy = dm_ready_a;
      @(negedge clk);
    end
    wait_a = 0;
    nvec++;
    if (wr_cyc != 3 || rd_cyc != 3) begin
      nerr++;
      $display("FAIL mem_hold: wr=%0d rd=%0d cycles, expected 3/3", wr_cyc, rd_cyc);
    end
    nvec++;
    if (bad != 0 || both != 0) begin
      nerr++;
      $display("FAIL mem_stable: unstable=%0d overlap=%0d expected 0/0", bad, both);
    end
    nvec++;
    if (lost != 0) begin
      nerr++;
      $display("FAIL mem_no_gap: %0d idle cycles after ready, expected 0", lost);
    end
    nvec++;
    if (lt_a.size() < base + 5 || lt_a[base + 2] - lt_a[base + 1] != 5 ||
        lt_a[base + 4] - lt_a[base + 3] != 5) begin
      nerr++;
      $display("FAIL mem_latency: memory ops with 2 waits did not take 5 cycles");
    end
    nvec++;
    if (acc_a !== 8'hA5 || ram_a[8'h10] !== 8'hA5 || halted_a !== 1'b1) begin
      nerr++;
      $display("FAIL mem_data: acc=%h ram=%h expected A5/A5", acc_a, ram_a[8'h10]);
    end
  endtask

  task automatic test_sub();
    logic [7:0] exp [12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd9, 8'd10, 8'd11, 8'd12,
                              8'd14, 8'd15};
    int base;
    clear_rom_a();
    rom_a[0]  = {OpLdi, 8'd4};
    rom_a[1]  = {OpSt, 8'h20};
    rom_a[2]  = {OpLdi, 8'd3};
    rom_a[3]  = {OpSub, 8'h20};
    rom_a[4]  = {OpJz, 8'd8};
    rom_a[5]  = {OpJc, 8'd9};
    rom_a[9]  = {OpAnd, 8'h20};
    rom_a[10] = {OpJc, 8'd13};
    rom_a[11] = {OpXor, 8'h20};
    rom_a[12] = {OpJz, 8'd14};
    rom_a[14] = {OpOr, 8'h20};
    base = log_a.size();
    start_a();
    run_a(200);
    for (int i = 0; i < 12; i++) begin
      nvec++;
      if (base + i >= log_a.size() || log_a[base + i] !== exp[i]) begin
        nerr++;
        $display("FAIL sub_pc[%0d]: got %h expected %h", i,
                 (base + i < log_a.size()) ? log_a[base + i] : 8'hxx, exp[i]);
      end
    end
    nvec++;
    if (lacc_a.size() < base + 5 || lacc_a[base + 4] !== 8'hFF) begin
      nerr++;
      $display("FAIL sub_result: 3-4 did not give FF");
    end
    nvec++;
    if (acc_a !== 8'h04 || fault_a !== 1'b0) begin
      nerr++;
      $display("FAIL sub_final: acc=%h fault=%b expected 04/0", acc_a, fault_a);
    end
  endtask

  task automatic test_stack();
    logic [7:0] exp [5] = '{8'd0, 8'd10, 8'd20, 8'd11, 8'd1};
    int base, ivs;
    clear_rom_a();
    rom_a[0]  = {OpCall, 8'd10};
    rom_a[10] = {OpCall, 8'd20};
    rom_a[11] = {OpRet, 8'd0};
    rom_a[20] = {OpRet, 8'd0};
    base = log_a.size();
    start_a();
    run_a(100);
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (base + i >= log_a.size() || log_a[base + i] !== exp[i]) begin
        nerr++;
        $display("FAIL stack_pc[%0d]: got %h expected %h", i,
                 (base + i < log_a.size()) ? log_a[base + i] : 8'hxx, exp[i]);
      end
    end
    nvec++;
    if (fault_a !== 1'b0) begin
      nerr++;
      $display("FAIL stack_nest_fault: fault=%b expected 0", fault_a);
    end
    rom_a[20] = {OpCall, 8'd30};
    base = log_a.size();
    start_a();
    run_a(100);
    nvec++;
    if ({halted_a, fault_a} !== 2'b11 || log_a.size() - base != 3) begin
      nerr++;
      $display("FAIL stack_overflow: halted/fault=%b fetches=%0d expected 11/3",
               {halted_a, fault_a}, log_a.size() - base);
    end
    ivs = 0;
    repeat (5) begin
      @(negedge clk);
      if (im_valid_a !== 1'b0 || dm_rd_a !== 1'b0 || dm_wr_a !== 1'b0) ivs++;
    end
    nvec++;
    if (ivs != 0) begin
      nerr++;
      $display("FAIL stack_halt_quiet: %0d cycles with requests, expected 0", ivs);
    end
    clear_rom_a();
    rom_a[0] = {OpRet, 8'd0};
    start_a();
    run_a(50);
    nvec++;
    if (fault_a !== 1'b1) begin
      nerr++;
      $display("FAIL stack_underflow: fault=%b expected 1", fault_a);
    end
  endtask

  task automatic test_illegal();
    bit found;
    clear_rom_a();
    rom_a[0] = {OpLdi, 8'h01};
    rom_a[1] = {8'h7F, 8'h00};
    start_a();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (im_valid_a === 1'b1 && im_addr_a === 8'd1) found = 1'b1;
      else @(negedge clk);
    end
    nvec++;
    if (!found) begin
      nerr++;
      $display("FAIL illegal_fetch: fetch of address 01 not seen");
    end
    @(negedge clk);
    nvec++;
    if ({halted_a, fault_a} !== 2'b00) begin
      nerr++;
      $display("FAIL illegal_early: halted/fault=%b during EXEC, expected 00", {halted_a, fault_a});
    end
    @(negedge clk);
    nvec++;
    if ({halted_a, fault_a, im_valid_a} !== 3'b110) begin
      nerr++;
      $display("FAIL illegal_fault: halted/fault/valid=%b expected 110",
               {halted_a, fault_a, im_valid_a});
    end
  endtask

  task automatic test_reset_mid_mem();
    bit found;
    int base;
    clear_rom_a();
    rom_a[0] = {OpLdi, 8'h01};
    rom_a[1] = {OpNop, 8'h00};
    rom_a[2] = {OpNop, 8'h00};
    rom_a[3] = {OpLd, 8'h10};
    wait_a = 1000;
    start_a();
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (dm_rd_a === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    nvec++;
    if (!found || im_addr_a !== 8'd3) begin
      nerr++;
      $display("FAIL midmem_setup: rd=%b pc=%h expected 1/03", dm_rd_a, im_addr_a);
    end
    rst_a = 1'b0;
    @(negedge clk);
    nvec++;
    if ({dm_rd_a, im_valid_a, fault_a} !== 3'b000 || im_addr_a !== 8'h00 || acc_a !== 8'h00)
    begin
      nerr++;
      $display("FAIL midmem_reset: rd/valid/fault=%b pc=%h acc=%h expected 000/00/00",
               {dm_rd_a, im_valid_a, fault_a}, im_addr_a, acc_a);
    end
    wait_a = 0;
    base = log_a.size();
    rst_a = 1'b1;
    run_a(50);
    nvec++;
    if (acc_a !== 8'hA5 || log_a.size() <= base || log_a[base] !== 8'h00) begin
      nerr++;
      $display("FAIL midmem_restart: acc=%h expected A5 with restart at 00", acc_a);
    end
  endtask

  task automatic test_wide();
    logic [5:0] exp [10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd63, 6'd0, 6'd10, 6'd11};
    int base;
    for (int i = 0; i < 64; i++) rom_b[i] = {OpHalt, 16'h0000};
    rom_b[0]  = {OpJz, 16'h000A};
    rom_b[1]  = {OpLdi, 16'hFFFF};
    rom_b[2]  = {OpSt, 16'h0005};
    rom_b[3]  = {OpLdi, 16'h0001};
    rom_b[4]  = {OpAdd, 16'h0005};
    rom_b[5]  = {OpJc, 16'h0FFF};
    rom_b[63] = {OpLdi, 16'h0000};
    rom_b[10] = {OpAddi, 16'h8000};
    base = log_b.size();
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int c = 0; c < 100 && halted_b !== 1'b1; c++) @(negedge clk);
    nvec++;
    if (halted_b !== 1'b1 || fault_b !== 1'b0) begin
      nerr++;
      $display("FAIL wide_halt: halted/fault=%b expected 10", {halted_b, fault_b});
    end
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if (base + i >= log_b.size() || log_b[base + i] !== exp[i]) begin
        nerr++;
        $display("FAIL wide_pc[%0d]: got %h expected %h", i,
                 (base + i < log_b.size()) ? log_b[base + i] : 6'hxx, exp[i]);
      end
    end
    nvec++;
    if (lacc_b.size() < base + 6 || lacc_b[base + 5] !== 16'h0000) begin
      nerr++;
      $display("FAIL wide_add: FFFF+1 did not wrap to 0000");
    end
    nvec++;
    if (acc_b !== 16'h8000) begin
      nerr++;
      $display("FAIL wide_final: acc=%h expected 8000", acc_b);
    end
  endtask

  initial begin
    rst_a      = 1'b0;
    rst_b      = 1'b0;
    im_ready_a = 1'b1;
    im_ready_b = 1'b1;
    test_reset();
    test_arith();
    test_mem();
    test_sub();
    test_stack();
    test_illegal();
    test_reset_mid_mem();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/simple_cpu_v2.md
# simple_cpu_v2

Parametrised successor to the 8-bit accumulator CPU top: an accumulator machine with a configurable data width and configurable instruction and data address widths. It adds a ready/valid handshake on both memory buses, so memories may insert wait states. It also adds Z/C flags, conditional jumps, a hardware CALL/RET stack, and HALT/fault reporting. It sits between the instruction ROM and the data RAM/peripheral bus and replaces the fixed-width top plus controller pair.

## Interface
Parameters:
- DATA_W, 8, accumulator, operand and data-bus width (≥8)
- IM_AW, 8, instruction address width (≤DATA_W)
- DM_AW, 8, data address width (≤DATA_W)
- STACK_DEPTH, 4, return-address stack entries (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clk
- im_valid  out  1  instruction fetch request
- im_addr  out  IM_AW  fetch address (PC)
- im_ready  in  1  im_instr valid this cycle; completes fetch
- im_instr  in  8+DATA_W  {opcode[7:0], operand[DATA_W-1:0]}
- dm_rd  out  1  data read request
- dm_wr  out  1  data write request
- dm_addr  out  DM_AW  operand[DM_AW-1:0]
- dm_wdata  out  DATA_W  accumulator
- dm_rdata  in  DATA_W  read data, valid with dm_ready
- dm_ready  in  1  completes current rd/wr
- acc_out  out  DATA_W  accumulator (debug)
- halted  out  1  core stopped
- fault  out  1  stack over/underflow or illegal opcode

## Operation
- Opcodes: 00 NOP; 01 LDI acc=imm; 02 LD acc=M[a]; 03 ST M[a]=acc; 04 ADD acc+=M[a]; 05 SUB acc-=M[a]; 06 AND; 07 OR; 08 XOR (all with M[a]); 09 ADDI acc+=imm; 0A JMP; 0B JZ; 0C JC; 0D CALL; 0E RET; 0F HALT. Any other opcode: illegal → fault=1, HALT.
- States: FETCH, EXEC, MEM, HALT.
- FETCH: im_valid=1, im_addr=pc. On im_ready, latch im_instr and go to EXEC.
- EXEC, register ops (NOP, LDI, ADDI, jumps, CALL, RET): complete this cycle, then FETCH.
- EXEC, memory ops (02–08): go to MEM.
- EXEC, HALT: go to HALT.
- MEM: dm_rd (02, 04–08) or dm_wr (03) held with a stable address and data until dm_ready. On dm_ready, the ALU result is written, pc advances, and the state returns to FETCH.
- Flags:
  - Z is set to (result==0) by LDI, LD, ADD, SUB, AND, OR, XOR, ADDI.
  - C is the carry-out of ADD/ADDI and the borrow of SUB (acc<M). Logic ops and loads clear C.
  - ST, NOP and jumps leave Z and C unchanged.
- Arithmetic: DATA_W-bit modulo, with carry taken from a DATA_W+1 sum.
- PC: next pc = pc+1 mod 2^IM_AW. Jump target = operand[IM_AW-1:0]. JZ/JC jump if the flag is set, otherwise pc+1.
- CALL: push pc+1 and jump. Push when the stack already holds STACK_DEPTH entries → fault, HALT, no push.
- RET: pop to pc. RET on an empty stack → fault, HALT.
- HALT: all requests deasserted. Only reset exits.

## Timing
- Reset values: pc=0, acc=0, Z=C=0, stack empty, state FETCH.
- Output reset values: im_valid=0 during reset, dm_rd=dm_wr=0, im_addr=0, dm_addr=0, dm_wdata=0, acc_out=0, halted=0, fault=0.
- The first im_valid occurs in the cycle after reset deasserts.
- Minimum latency: 2 cycles for register ops, 3 cycles for memory ops, each plus any wait states.
- Handshake rules:
  - Requests are registered outputs and never drop before ready.
  - im_ready or dm_ready while no request is outstanding is ignored.
  - dm_rd and dm_wr are never high together.
- Reset mid-operation (any state, including MEM with a request pending): requests drop the following cycle and all state returns to reset values. The pending transaction is abandoned.
- halted and fault are registered. They are set in the cycle after the faulting EXEC.

## Structure
- Package simple_cpu_v2_pkg holds the opcode localparams, the state enum (FETCH, EXEC, MEM, HALT), and the flag bit indices.
- Sub-module simple_cpu_v2_alu: combinational DATA_W ALU (pass, add, sub, and, or, xor) returning {carry, result}.
- Return stack is an inline register array with a pointer width of $clog2(STACK_DEPTH+1).

## Test plan
- Reset, then LDI 5; ADDI 250; JC 6 with im_ready tied high → acc=255, C=0, pc=3 (no jump); the next instruction ADDI 1 gives acc=0, Z=1, C=1.
- ST 0x10, then LD 0x10 with dm_ready delayed 3 cycles → dm_wr held 3 cycles with addr 0x10; acc reloaded equal; zero lost cycles after ready.
- SUB with acc=3, M=4 → acc=0xFF (DATA_W=8), C=1, Z=0; JZ not taken, JC taken.
- STACK_DEPTH=2: CALL, CALL, RET, RET → returns to correct addresses; a third nested CALL → fault=1, halted=1, no further im_valid.
- Opcode 0x7F → fault=1, halted=1. Reset asserted while in MEM with dm_rd high → dm_rd=0 the next cycle, pc=0, fault=0.
- DATA_W=16, IM_AW=6: JMP 0x0FFF lands at pc=0x3F; the increment wraps to 0; ADD carry out of bit 15 sets C.
